// File: rtl/otg_hpi_bus_ctrl_if.sv
// Avalon-MM slave port of the OTG HPI bus controller.
// Handshake: a request (avs_read or avs_write) is held until a cycle with avs_waitrequest low;
// that cycle completes the transfer, and avs_readdata is valid in it for reads.
interface otg_hpi_bus_ctrl_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [15:0] avs_writedata;
    logic [15:0] avs_readdata;
    logic        avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/otg_hpi_bus_ctrl.sv
// Sequences one timed CY7C67200 HPI read or write cycle per Avalon access.
// All pin outputs are registered alongside the state so they change on state entry.
module otg_hpi_bus_ctrl #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    otg_hpi_bus_ctrl_if.slave avs,
    output logic [1:0]        otg_addr,
    output logic              otg_cs_n,
    output logic              otg_rd_n,
    output logic              otg_wr_n,
    output logic [15:0]       otg_data_out,
    output logic              otg_data_oe,
    input  logic [15:0]       otg_data_in,
    output logic [2:0]        state_dbg
);
    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, HOLD, ACK, RECOVER
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_write;

    assign avs.avs_waitrequest = (avs.avs_read | avs.avs_write) && (state != ACK);
    assign state_dbg           = state;

    // Asynchronous reset releases every strobe and the pin driver without waiting for clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            cnt              <= '0;
            is_write         <= 1'b0;
            otg_addr         <= 2'd0;
            otg_cs_n         <= 1'b1;
            otg_rd_n         <= 1'b1;
            otg_wr_n         <= 1'b1;
            otg_data_out     <= 16'h0000;
            otg_data_oe      <= 1'b0;
            avs.avs_readdata <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (avs.avs_write || avs.avs_read) begin
                        is_write <= avs.avs_write;
                        otg_addr <= avs.avs_address;
                        otg_cs_n <= 1'b0;
                        if (avs.avs_write) begin
                            otg_data_out <= avs.avs_writedata;
                            otg_data_oe  <= 1'b1;
                        end
                        cnt   <= SETUP_LD;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        if (is_write) otg_wr_n <= 1'b0;
                        else          otg_rd_n <= 1'b0;
                        cnt   <= STROBE_LD;
                        state <= STROBE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        otg_rd_n <= 1'b1;
                        otg_wr_n <= 1'b1;
                        if (!is_write) avs.avs_readdata <= otg_data_in;
                        cnt   <= HOLD_LD;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        otg_cs_n     <= 1'b1;
                        otg_data_oe  <= 1'b0;
                        otg_addr     <= 2'd0;
                        otg_data_out <= 16'h0000;
                        state        <= ACK;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ACK: begin
                    if (RECOVER_CYC == 0) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= RECOVER_LD;
                        state <= RECOVER;
                    end
                end
                RECOVER: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - CNT_ONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
